// File: rtl/safe_zone_ctrl_pkg.sv
// Shared constants and types for the safe-zone map controller.
// Coordinate widths follow the screen size.
package safe_zone_ctrl_pkg;
    localparam int SCREEN_WIDTH  = 800;
    localparam int SCREEN_HEIGHT = 600;
    localparam int X_W           = $clog2(SCREEN_WIDTH);
    localparam int Y_W           = $clog2(SCREEN_HEIGHT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_RDY,
        ST_SERVE
    } state_e;
endpackage

// File: rtl/safe_zone_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves
// just past the winner. The pointer holds when nothing is granted.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        sum   = '0;
        idx   = '0;
        if (en_i) begin
            for (int i = N - 1; i >= 0; i--) begin
                sum = {1'b0, ptr_q} + (PW+1)'(i);
                if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
                idx = sum[PW-1:0];
                if (req_i[idx]) begin
                    gnt_o      = '0;
                    gnt_o[idx] = 1'b1;
                    ptr_d      = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
endmodule

// File: rtl/safe_zone_ctrl.sv
// Safe-zone map controller: sequences level regeneration with a timeout and
// time-shares the map's single lookup port among N_REQ requesters.
module safe_zone_ctrl
    import safe_zone_ctrl_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        i_new_level,
    output logic                        o_regen,
    input  logic                        i_map_rdy,
    output logic                        o_level_ready,
    output logic [7:0]                  o_level,
    output logic                        o_err,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ-1:0][X_W-1:0]   i_req_x,
    input  logic [N_REQ-1:0][Y_W-1:0]   i_req_y,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [N_REQ-1:0]            o_rsp_valid,
    output logic                        o_rsp_safe,
    output logic [X_W-1:0]              o_map_x,
    output logic [Y_W-1:0]              o_map_y,
    input  logic                        i_map_safe
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [7:0]       level_q, level_d;
    logic             err_q, err_d;
    logic [N_REQ-1:0] rsp_valid_q;
    logic             rsp_safe_q;
    logic             arb_en;
    logic             regen_busy;
    logic             timeout;

    assign regen_busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT_BUSY) ||
                        (state_q == ST_WAIT_RDY);
    assign timeout    = regen_busy && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // The counter doubles as the WAIT_BUSY dwell timer: it reads 1 and 2 there.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        pend_d  = pend_q;
        level_d = level_q;
        err_d   = err_q;
        if (regen_busy) begin
            cnt_d = cnt_q + 1'b1;
            if (i_new_level) pend_d = 1'b1;
        end
        case (state_q)
            ST_IDLE:      if (i_new_level) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!i_map_rdy || cnt_q == CW'(2)) state_d = ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                if (i_map_rdy) begin
                    state_d = ST_SERVE;
                    level_d = level_q + 8'd1;
                end
            end
            ST_SERVE: begin
                if (i_new_level || pend_q) begin
                    state_d = ST_ISSUE;
                    pend_d  = 1'b0;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d = ST_IDLE;
            level_d = level_q;
            err_d   = 1'b1;
            pend_d  = 1'b0;
        end
    end

    // No lookups in a SERVE cycle that is about to leave for ISSUE.
    always_comb begin
        o_regen       = (state_q == ST_ISSUE);
        o_level_ready = (state_q == ST_SERVE);
        arb_en        = (state_q == ST_SERVE) && !i_new_level && !pend_q;
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk   (clk),
        .arst  (arst),
        .en_i  (arb_en),
        .req_i (i_req),
        .gnt_o (o_gnt)
    );

    always_comb begin
        o_map_x = '0;
        o_map_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (o_gnt[i]) begin
                o_map_x = i_req_x[i];
                o_map_y = i_req_y[i];
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rsp_valid_q <= '0;
            rsp_safe_q  <= 1'b0;
        end else begin
            rsp_valid_q <= o_gnt;
            rsp_safe_q  <= i_map_safe;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_safe  = rsp_safe_q;
    assign o_level     = level_q;
    assign o_err       = err_q;
endmodule
